// File: rtl/ll_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ll_fifo_pkg
// Purpose : shared width helpers and slot/count types for the linked-list
//           multi-queue FIFO (ll_multi_fifo, ll_free_list).
// Ports   : none (package).
// Modules size their own slot/count types from their parameters with the
// width functions below; ptr_t / cnt_t are the types for the default
// four-entry configuration.
// ---------------------------------------------------------------------------
package ll_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int sel_w(input int num_fifos);
    return (num_fifos > 1) ? $clog2(num_fifos) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_DEPTH = 4;

  typedef logic [ptr_w(DEF_DEPTH)-1:0] ptr_t;
  typedef logic [cnt_w(DEF_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/ll_free_list.sv
// ---------------------------------------------------------------------------
// ll_free_list
// Purpose : free-slot list of the shared RAM. Holds fhead/ftail/fcnt and
//           requests the link write that appends a released slot.
// Ports   :
//   clk, rst          clock, async active-low reset
//   alloc             a push consumes fhead this cycle
//   rel, rel_slot     a pop returns rel_slot this cycle
//   fhead_nxt         nxt[fhead], read from the shared next-pointer array
//   fhead, fcnt       current free head and number of free slots
//   link_we/addr/data write request nxt[ftail] = rel_slot; the top applies
//                     it after the queue link write
// ---------------------------------------------------------------------------
module ll_free_list
  import ll_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = ptr_w(DEPTH),
  parameter int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 rel,
  input  logic [PTR_WIDTH-1:0] rel_slot,
  input  logic [PTR_WIDTH-1:0] fhead_nxt,
  output logic [PTR_WIDTH-1:0] fhead,
  output logic [CNT_WIDTH-1:0] fcnt,
  output logic                 link_we,
  output logic [PTR_WIDTH-1:0] link_addr,
  output logic [PTR_WIDTH-1:0] link_data
);

  typedef logic [PTR_WIDTH-1:0] slot_t;
  typedef logic [CNT_WIDTH-1:0] occ_t;

  slot_t ftail;
  logic  fcnt_zero;
  logic  fcnt_one;

  assign fcnt_zero = (fcnt == '0);
  assign fcnt_one  = (fcnt == occ_t'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fhead <= '0;
      ftail <= slot_t'(DEPTH - 1);
      fcnt  <= occ_t'(DEPTH);
    end else begin
      case ({alloc, rel})
        2'b10: begin
          fhead <= fhead_nxt;
          fcnt  <= fcnt - occ_t'(1);
        end
        2'b01: begin
          if (fcnt_zero) fhead <= rel_slot;
          ftail <= rel_slot;
          fcnt  <= fcnt + occ_t'(1);
        end
        2'b11: begin
          // The last free slot goes to the push, so the released slot
          // becomes the whole free list.
          fhead <= fcnt_one ? rel_slot : fhead_nxt;
          ftail <= rel_slot;
        end
        default: ;
      endcase
    end
  end

  // Appending needs a link only when the list keeps an existing tail.
  assign link_we   = rel && !fcnt_zero && !(alloc && fcnt_one);
  assign link_addr = ftail;
  assign link_data = rel_slot;

endmodule

// File: rtl/ll_multi_fifo.sv
// ---------------------------------------------------------------------------
// ll_multi_fifo
// Purpose : NUM_FIFOS logical FIFOs sharing one DEPTH-entry data RAM, each
//           queue a linked list through nxt[]; unused slots form a free list.
// Ports   :
//   clk, rst            clock, async active-low reset
//   push, push_sel      enqueue request and target queue
//   data_in             push data
//   pop, pop_sel        dequeue request and source queue
//   data_out            head word of queue pop_sel (fall-through)
//   empty, qfull        per-queue empty / count == QUOTA
//   full                no free slot left
//   count               per-queue occupancy, CNT_WIDTH bits per queue
//   overflow/underflow  sticky: a push / pop was dropped
// ---------------------------------------------------------------------------
module ll_multi_fifo
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int QUOTA     = DEPTH,
  parameter int PTR_WIDTH = ptr_w(DEPTH),
  parameter int SEL_WIDTH = sel_w(NUM_FIFOS),
  parameter int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [SEL_WIDTH-1:0]           push_sel,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           pop,
  input  logic [SEL_WIDTH-1:0]           pop_sel,
  output logic [WIDTH-1:0]               data_out,
  output logic [NUM_FIFOS-1:0]           empty,
  output logic [NUM_FIFOS-1:0]           qfull,
  output logic                           full,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
  output logic                           overflow,
  output logic                           underflow
);

  typedef logic [PTR_WIDTH-1:0] slot_t;
  typedef logic [CNT_WIDTH-1:0] occ_t;

  logic [WIDTH-1:0] mem [DEPTH];
  slot_t            nxt [DEPTH];

  slot_t head_a [NUM_FIFOS];
  slot_t tail_a [NUM_FIFOS];
  occ_t  cnt_a  [NUM_FIFOS];

  slot_t fhead;
  occ_t  fcnt;
  logic  f_link_we;
  slot_t f_link_addr;
  slot_t f_link_data;

  logic                 push_sel_ok, pop_sel_ok;
  logic [SEL_WIDTH-1:0] push_idx, pop_idx;
  logic                 push_ok, pop_ok;
  logic                 q_link_we;
  slot_t                pop_head;

  // Out-of-range selects are dropped; the index is forced to 0 so array
  // reads stay in bounds.
  assign push_sel_ok = (int'(push_sel) < NUM_FIFOS);
  assign pop_sel_ok  = (int'(pop_sel) < NUM_FIFOS);
  assign push_idx    = push_sel_ok ? push_sel : '0;
  assign pop_idx     = pop_sel_ok ? pop_sel : '0;

  assign push_ok  = push && push_sel_ok && !full && !qfull[push_idx];
  assign pop_ok   = pop && pop_sel_ok && !empty[pop_idx];
  assign pop_head = head_a[pop_idx];
  assign full     = (fcnt == '0);
  assign data_out = mem[pop_head];

  ll_free_list #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_free (
    .clk       (clk),
    .rst       (rst),
    .alloc     (push_ok),
    .rel       (pop_ok),
    .rel_slot  (pop_head),
    .fhead_nxt (nxt[fhead]),
    .fhead     (fhead),
    .fcnt      (fcnt),
    .link_we   (f_link_we),
    .link_addr (f_link_addr),
    .link_data (f_link_data)
  );

  always_ff @(posedge clk) begin
    if (push_ok) mem[fhead] <= data_in;
  end

  // Queue link for a push onto a non-empty queue, then the free-list link.
  // The two addresses are never the same slot (queue tail vs free tail).
  assign q_link_we = push_ok && (cnt_a[push_idx] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] <= slot_t'((i + 1) % DEPTH);
    end else begin
      if (q_link_we) nxt[tail_a[push_idx]] <= fhead;
      if (f_link_we) nxt[f_link_addr] <= f_link_data;
    end
  end

  for (genvar q = 0; q < NUM_FIFOS; q++) begin : g_q
    slot_t head_r, tail_r;
    occ_t  cnt_r;
    logic  push_q, pop_q;

    assign push_q = push_ok && (push_idx == SEL_WIDTH'(q));
    assign pop_q  = pop_ok && (pop_idx == SEL_WIDTH'(q));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        head_r <= '0;
        tail_r <= '0;
        cnt_r  <= '0;
      end else begin
        // Pop-then-push: a queue emptied by the pop restarts at the new slot.
        if (pop_q) begin
          head_r <= (push_q && cnt_r == occ_t'(1)) ? fhead : nxt[head_r];
        end else if (push_q && cnt_r == '0) begin
          head_r <= fhead;
        end
        if (push_q) tail_r <= fhead;
        case ({push_q, pop_q})
          2'b10:   cnt_r <= cnt_r + occ_t'(1);
          2'b01:   cnt_r <= cnt_r - occ_t'(1);
          default: ;
        endcase
      end
    end

    assign head_a[q] = head_r;
    assign tail_a[q] = tail_r;
    assign cnt_a[q]  = cnt_r;
    assign empty[q]  = (cnt_r == '0);
    assign qfull[q]  = (cnt_r == occ_t'(QUOTA));
    assign count[q*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !push_ok) overflow <= 1'b1;
      if (pop && !pop_ok) underflow <= 1'b1;
    end
  end

  int occ_sum;

  always_comb begin
    occ_sum = int'(fcnt);
    for (int q = 0; q < NUM_FIFOS; q++) occ_sum += int'(cnt_a[q]);
  end

  a_occupancy: assert property (@(posedge clk) disable iff (!rst) occ_sum == DEPTH);

endmodule

// File: tb/tb_ll_multi_fifo.sv
module tb_ll_multi_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DEPTH 4, two queues, QUOTA 4
  logic       push = 0, pop = 0;
  logic       push_sel = 0, pop_sel = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic [1:0] empty, qfull;
  logic       full, overflow, underflow;
  logic [5:0] count;

  ll_multi_fifo u_dut (
    .clk(clk), .rst(rst), .push(push), .push_sel(push_sel), .data_in(data_in),
    .pop(pop), .pop_sel(pop_sel), .data_out(data_out), .empty(empty),
    .qfull(qfull), .full(full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  // Second instance: DEPTH 4, three queues, QUOTA 2 (select value 3 is invalid)
  logic       qpush = 0, qpop = 0;
  logic [1:0] qpush_sel = 0, qpop_sel = 0;
  logic [7:0] qdata_in = 0;
  logic [7:0] qdata_out;
  logic [2:0] qempty, qqfull;
  logic       qfull_o, qovf, qunf;
  logic [8:0] qcount;

  ll_multi_fifo #(.NUM_FIFOS(3), .QUOTA(2)) u_dut_q (
    .clk(clk), .rst(rst), .push(qpush), .push_sel(qpush_sel), .data_in(qdata_in),
    .pop(qpop), .pop_sel(qpop_sel), .data_out(qdata_out), .empty(qempty),
    .qfull(qqfull), .full(qfull_o), .count(qcount), .overflow(qovf),
    .underflow(qunf)
  );

  int n_chk = 0;
  int n_fail = 0;

  byte unsigned mq [2][$];
  byte unsigned exp_q [$];
  bit ovf_m = 0, unf_m = 0;
  logic [7:0] mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: whenever the DUT presents a pop of a non-empty queue
  always @(negedge clk) begin
    if (rst && pop && !empty[pop_sel]) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got pop of %0h expected no pop at %0t", data_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data", {24'd0, data_out}, {24'd0, mon_e});
      end
    end
  end

  // Drive one cycle on the main instance; the model decides acceptance from
  // the state before the edge, then applies pop before push.
  task automatic step(input bit pu, input int ps, input byte unsigned d,
                      input bit po, input int pos);
    bit pok, ook;
    int tot;
    tot = mq[0].size() + mq[1].size();
    pok = pu && (tot < 4) && (mq[ps].size() < 4);
    ook = po && (mq[pos].size() > 0);
    push = pu; push_sel = ps[0]; data_in = d;
    pop  = po; pop_sel  = pos[0];
    if (ook) exp_q.push_back(mq[pos].pop_front());
    if (pok) mq[ps].push_back(d);
    if (pu && !pok) ovf_m = 1;
    if (po && !ook) unf_m = 1;
    @(posedge clk);
    #1;
    push = 0;
    pop  = 0;
  endtask

  task automatic check_state(input string tag);
    int tot;
    tot = mq[0].size() + mq[1].size();
    check({tag, "_cnt0"}, count[2:0], mq[0].size());
    check({tag, "_cnt1"}, count[5:3], mq[1].size());
    check({tag, "_empty"}, empty, {mq[1].size() == 0, mq[0].size() == 0});
    check({tag, "_qfull"}, qfull, {mq[1].size() == 4, mq[0].size() == 4});
    check({tag, "_full"}, full, tot == 4);
    check({tag, "_ovf"}, overflow, ovf_m);
    check({tag, "_unf"}, underflow, unf_m);
  endtask

  task automatic clear_model();
    mq[0].delete();
    mq[1].delete();
    exp_q.delete();
    ovf_m = 0;
    unf_m = 0;
  endtask

  // Called just after a rising edge; reset asserts between edges.
  task automatic do_reset(input string tag);
    rst = 0;
    #2;
    check({tag, "_rst_empty"}, empty, 2'b11);
    check({tag, "_rst_count"}, count, 6'd0);
    clear_model();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic qstep(input bit pu, input logic [1:0] ps, input logic [7:0] d,
                       input bit po, input logic [1:0] pos);
    qpush = pu; qpush_sel = ps; qdata_in = d;
    qpop  = po; qpop_sel  = pos;
    @(posedge clk);
    #1;
    qpush = 0;
    qpop  = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    check_state("reset");
    check("reset_q_empty", qempty, 3'b111);

    // Main: basic pushes and fall-through head
    step(1, 0, 8'hA1, 0, 0);
    step(1, 0, 8'hA2, 0, 0);
    step(1, 1, 8'hB1, 0, 0);
    check_state("push3");
    pop_sel = 0;
    #1;
    check("peek_a1", data_out, 8'hA1);

    // Fill, then overflow on a full RAM
    step(1, 1, 8'hC1, 0, 0);
    check_state("fill");
    step(1, 1, 8'hEE, 0, 0);
    check_state("ovf_full");
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check_state("drain1");

    // Same-queue push+pop with one entry
    do_reset("t4");
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 1, 0);
    check_state("samequeue");
    pop_sel = 0;
    #1;
    check("peek_22", data_out, 8'h22);
    step(0, 0, 0, 1, 0);
    check_state("t4_drain");

    // Full blocks push even with a simultaneous pop
    do_reset("t5");
    step(1, 0, 8'h01, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(1, 1, 8'h03, 0, 0);
    step(1, 1, 8'h04, 0, 0);
    check_state("t5_full");
    step(1, 1, 8'h33, 1, 0);
    check_state("t5_blocked");
    step(1, 1, 8'h33, 0, 0);
    check_state("t5_refill");
    // One free slot left, then push+pop on different queues
    step(0, 0, 0, 1, 1);
    check_state("t5_fcnt1");
    step(1, 0, 8'h44, 1, 1);
    check_state("t5_pp_fcnt1");
    step(1, 0, 8'h55, 0, 0);
    check_state("t5_full2");
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check_state("t5_drain");
    step(0, 0, 0, 1, 1);
    check_state("t5_underflow");

    // Quota instance
    do_reset("t6");
    qstep(1, 2'd0, 8'h61, 0, 2'd0);
    qstep(1, 2'd0, 8'h62, 0, 2'd0);
    qstep(1, 2'd0, 8'h63, 0, 2'd0);
    check("quota_cnt0", qcount[2:0], 3'd2);
    check("quota_qfull", qqfull, 3'b001);
    check("quota_full", qfull_o, 1'b0);
    check("quota_ovf", qovf, 1'b1);
    check("quota_unf0", qunf, 1'b0);
    qpop_sel = 2'd0;
    #1;
    check("quota_peek", qdata_out, 8'h61);
    qstep(1, 2'd2, 8'h71, 1, 2'd1);
    check("quota_unf", qunf, 1'b1);
    check("quota_cnt2", qcount[8:6], 3'd1);
    check("quota_cnt1", qcount[5:3], 3'd0);
    do_reset("t7");
    qstep(0, 2'd0, 8'h00, 1, 2'd3);
    check("badsel_unf", qunf, 1'b1);
    check("badsel_ovf0", qovf, 1'b0);
    qstep(1, 2'd3, 8'h99, 0, 2'd0);
    check("badsel_ovf", qovf, 1'b1);
    check("badsel_count", qcount, 9'd0);
    check("badsel_empty", qempty, 3'b111);

    // Random traffic with a reset dropped mid-burst
    do_reset("rnd");
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        push = 1; push_sel = 0; data_in = 8'h5A;
        pop = 1; pop_sel = 1;
        #2;
        rst = 0;
        #1;
        check("midrst_empty", empty, 2'b11);
        check("midrst_count", count, 6'd0);
        check("midrst_full", full, 1'b0);
        push = 0;
        pop = 0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1;
        check_state("midrst");
      end else begin
        step($urandom_range(0, 99) < 55, $urandom_range(0, 1), 8'($urandom),
             $urandom_range(0, 99) < 45, $urandom_range(0, 1));
        check_state("rnd");
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
    end
    check_state("final");
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
